// File: rtl/mem_arbiter.sv
// Arbitrates the single external memory port between the CPU and the front-panel loader.
// CPU has priority; a starvation counter forces a loader grant after STARVE_MAX CPU wins.
module mem_arbiter #(
   parameter int unsigned MEM_LAT    = 2,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_wdata,
   output logic [7:0]  cpu_rdata,
   output logic        cpu_ready,
   input  logic        ldr_req,
   input  logic        ldr_we,
   input  logic [15:0] ldr_addr,
   input  logic [7:0]  ldr_wdata,
   output logic [7:0]  ldr_rdata,
   output logic        ldr_ready,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_wdata,
   input  logic [7:0]  mem_rdata,
   output logic        mem_read,
   output logic        mem_write,
   output logic [1:0]  owner
);

   typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

   localparam logic [3:0] LatInit   = 4'(MEM_LAT - 1);
   localparam logic [3:0] StarveMax = 4'(STARVE_MAX);
   localparam logic [1:0] OwnNone   = 2'b00;
   localparam logic [1:0] OwnCpu    = 2'b01;
   localparam logic [1:0] OwnLdr    = 2'b10;

   state_e      state_q, state_d;
   logic [3:0]  lat_cnt_q, lat_cnt_d;
   logic [3:0]  starve_cnt_q, starve_cnt_d;
   logic [15:0] addr_q, addr_d;
   logic [7:0]  wdata_q, wdata_d;
   logic        we_q, we_d;
   logic [1:0]  owner_q, owner_d;
   logic [7:0]  cpu_rdata_q, cpu_rdata_d;
   logic [7:0]  ldr_rdata_q, ldr_rdata_d;
   logic        ldr_win;

   always_comb begin
      state_d      = state_q;
      lat_cnt_d    = lat_cnt_q;
      starve_cnt_d = starve_cnt_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      we_d         = we_q;
      owner_d      = owner_q;
      cpu_rdata_d  = cpu_rdata_q;
      ldr_rdata_d  = ldr_rdata_q;
      ldr_win      = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (cpu_req || ldr_req) begin
               ldr_win = ldr_req && (!cpu_req || (starve_cnt_q == StarveMax));
               if (ldr_win) begin
                  addr_d       = ldr_addr;
                  wdata_d      = ldr_wdata;
                  we_d         = ldr_we;
                  owner_d      = OwnLdr;
                  starve_cnt_d = 4'd0;
               end else begin
                  addr_d  = cpu_addr;
                  wdata_d = cpu_wdata;
                  we_d    = cpu_we;
                  owner_d = OwnCpu;
                  // Count only grants the loader actually lost out on.
                  if (!ldr_req) begin
                     starve_cnt_d = 4'd0;
                  end else if (starve_cnt_q != StarveMax) begin
                     starve_cnt_d = starve_cnt_q + 4'd1;
                  end
               end
               lat_cnt_d = LatInit;
               state_d   = StAccess;
            end
         end
         StAccess: begin
            if (lat_cnt_q == 4'd0) begin
               if (!we_q) begin
                  if (owner_q == OwnCpu) begin
                     cpu_rdata_d = mem_rdata;
                  end else begin
                     ldr_rdata_d = mem_rdata;
                  end
               end
               state_d = StResp;
            end else begin
               lat_cnt_d = lat_cnt_q - 4'd1;
            end
         end
         StResp: begin
            state_d = StIdle;
            owner_d = OwnNone;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StIdle;
         lat_cnt_q    <= 4'd0;
         starve_cnt_q <= 4'd0;
         addr_q       <= 16'd0;
         wdata_q      <= 8'd0;
         we_q         <= 1'b0;
         owner_q      <= OwnNone;
         cpu_rdata_q  <= 8'd0;
         ldr_rdata_q  <= 8'd0;
      end else begin
         state_q      <= state_d;
         lat_cnt_q    <= lat_cnt_d;
         starve_cnt_q <= starve_cnt_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         we_q         <= we_d;
         owner_q      <= owner_d;
         cpu_rdata_q  <= cpu_rdata_d;
         ldr_rdata_q  <= ldr_rdata_d;
      end
   end

   // Strobes decode straight from state so an async reset drops them at once.
   assign mem_read  = (state_q == StAccess) && !we_q;
   assign mem_write = (state_q == StAccess) && we_q;
   assign cpu_ready = (state_q == StResp) && (owner_q == OwnCpu);
   assign ldr_ready = (state_q == StResp) && (owner_q == OwnLdr);
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign owner     = owner_q;
   assign cpu_rdata = cpu_rdata_q;
   assign ldr_rdata = ldr_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: agents push expected transactions, a negedge monitor
// checks every completed access, grant order, bus exclusivity and read-data holding.
module tb_mem_arbiter;

   localparam int unsigned MemLat    = 2;
   localparam int unsigned StarveMax = 4;

   typedef struct {
      logic        we;
      logic [15:0] addr;
      logic [7:0]  wdata;
      logic [7:0]  rdata;
   } xact_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_req, cpu_we, ldr_req, ldr_we;
   logic [15:0] cpu_addr, ldr_addr, mem_addr;
   logic [7:0]  cpu_wdata, ldr_wdata, cpu_rdata, ldr_rdata, mem_wdata, mem_rdata;
   logic        cpu_ready, ldr_ready, mem_read, mem_write;
   logic [1:0]  owner;

   logic [7:0]  mem [0:255];
   xact_t       exp_cpu[$];
   xact_t       exp_ldr[$];
   logic [1:0]  exp_grant[$];
   int          total = 0;
   int          bad = 0;

   logic [15:0] acc_addr;
   logic [7:0]  acc_wdata;
   logic        acc_we;
   logic [1:0]  acc_owner;
   int          acc_len = 0;
   logic        prev_strobe = 1'b0;
   logic        prev_ready = 1'b0;
   logic [7:0]  cpu_hold = 8'd0;
   logic [7:0]  ldr_hold = 8'd0;
   logic [1:0]  who;
   xact_t       x;

   mem_arbiter #(.MEM_LAT(MemLat), .STARVE_MAX(StarveMax)) dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
      .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
      .ldr_rdata(ldr_rdata), .ldr_ready(ldr_ready),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_read(mem_read), .mem_write(mem_write), .owner(owner)
   );

   always #5 clk = ~clk;

   assign mem_rdata = mem_read ? mem[mem_addr[7:0]] : 8'h00;

   always @(posedge clk) begin
      if (mem_write) mem[mem_addr[7:0]] <= mem_wdata;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic miss(input string name);
      total++;
      bad++;
      $display("FAIL %s at %0t", name, $time);
   endtask

   // Monitor: away from the active edge, check invariants and retire transactions.
   always @(negedge clk) begin
      if (rst) begin
         acc_len     = 0;
         prev_strobe = 1'b0;
         prev_ready  = 1'b0;
         cpu_hold    = 8'd0;
         ldr_hold    = 8'd0;
      end else begin
         chk("bus_excl", {31'd0, mem_read & mem_write}, 32'd0);
         if (mem_read || mem_write) begin
            acc_len++;
            acc_addr  = mem_addr;
            acc_we    = mem_write;
            acc_wdata = mem_wdata;
            acc_owner = owner;
         end
         if (cpu_ready || ldr_ready) begin
            who = cpu_ready ? 2'b01 : 2'b10;
            chk("ready_excl", {31'd0, cpu_ready & ldr_ready}, 32'd0);
            chk("ready_pulse", {31'd0, prev_ready}, 32'd0);
            chk("ready_after_strobe", {31'd0, prev_strobe}, 32'd1);
            chk("owner_resp", {30'd0, owner}, {30'd0, who});
            if (exp_grant.size() > 0) chk("grant_order", {30'd0, who},
                                          {30'd0, exp_grant.pop_front()});
            else miss("unexpected_grant");
            if (who == 2'b01 ? exp_cpu.size() > 0 : exp_ldr.size() > 0) begin
               x = (who == 2'b01) ? exp_cpu.pop_front() : exp_ldr.pop_front();
               chk("acc_owner", {30'd0, acc_owner}, {30'd0, who});
               chk("acc_len", acc_len, MemLat);
               chk("acc_addr", {16'd0, acc_addr}, {16'd0, x.addr});
               chk("acc_we", {31'd0, acc_we}, {31'd0, x.we});
               if (x.we) chk("acc_wdata", {24'd0, acc_wdata}, {24'd0, x.wdata});
               else if (who == 2'b01) cpu_hold = x.rdata;
               else ldr_hold = x.rdata;
            end else begin
               miss("unexpected_ready");
            end
            acc_len = 0;
         end
         chk("cpu_rdata", {24'd0, cpu_rdata}, {24'd0, cpu_hold});
         chk("ldr_rdata", {24'd0, ldr_rdata}, {24'd0, ldr_hold});
         prev_strobe = mem_read | mem_write;
         prev_ready  = cpu_ready | ldr_ready;
      end
   end

   task automatic cpu_xact(input logic we, input logic [15:0] a, input logic [7:0] wd,
                           input logic [7:0] rd);
      xact_t t;
      int n = 0;
      t.we = we; t.addr = a; t.wdata = wd; t.rdata = rd;
      exp_cpu.push_back(t);
      cpu_we = we; cpu_addr = a; cpu_wdata = wd; cpu_req = 1'b1;
      do begin
         @(negedge clk);
         n++;
      end while (!cpu_ready && n < 60);
      if (!cpu_ready) miss("cpu_timeout");
      @(posedge clk);
      #1 cpu_req = 1'b0;
   endtask

   task automatic ldr_xact(input logic we, input logic [15:0] a, input logic [7:0] wd,
                           input logic [7:0] rd);
      xact_t t;
      int n = 0;
      t.we = we; t.addr = a; t.wdata = wd; t.rdata = rd;
      exp_ldr.push_back(t);
      ldr_we = we; ldr_addr = a; ldr_wdata = wd; ldr_req = 1'b1;
      do begin
         @(negedge clk);
         n++;
      end while (!ldr_ready && n < 80);
      if (!ldr_ready) miss("ldr_timeout");
      @(posedge clk);
      #1 ldr_req = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
      mem[8'h34] = 8'hA5;
      rst = 1'b1;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'd0; cpu_wdata = 8'd0;
      ldr_req = 1'b0; ldr_we = 1'b0; ldr_addr = 16'd0; ldr_wdata = 8'd0;
      repeat (3) @(negedge clk);
      chk("rst_outputs", {cpu_rdata, ldr_rdata, 6'd0, cpu_ready, ldr_ready, mem_read,
                          mem_write, owner}, 32'd0);
      chk("rst_mem_bus", {mem_addr, mem_wdata, 8'd0}, 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // T1: CPU read 0x1234 returns 0xA5
      exp_grant.push_back(2'b01);
      cpu_xact(1'b0, 16'h1234, 8'h00, 8'hA5);

      // T2: loader write 0x0100 <- 0x3C
      exp_grant.push_back(2'b10);
      ldr_xact(1'b1, 16'h0100, 8'h3C, 8'h00);

      // T3: both requesting back to back -> C,C,C,C,L,C,C,C,C,L
      for (int i = 0; i < 10; i++) exp_grant.push_back((i == 4 || i == 9) ? 2'b10 : 2'b01);
      fork
         begin
            for (int i = 0; i < 8; i++) begin
               logic [15:0] a;
               a = 16'h0020 + 16'(i);
               cpu_xact(1'b0, a, 8'h00, a[7:0] ^ 8'h5A);
            end
         end
         begin
            for (int j = 0; j < 2; j++) ldr_xact(1'b1, 16'h0080 + 16'(j), 8'hC0 + 8'(j), 8'h00);
         end
      join

      // T4: loader request arriving mid CPU access waits for the next IDLE
      exp_grant.push_back(2'b01);
      exp_grant.push_back(2'b10);
      fork
         cpu_xact(1'b0, 16'h0033, 8'h00, 8'h33 ^ 8'h5A);
         begin
            repeat (2) @(negedge clk);
            chk("t4_cpu_owns", {30'd0, owner}, 32'd1);
            ldr_xact(1'b0, 16'h0081, 8'h00, 8'hC1);
         end
      join

      // T5: reset on the second ACCESS cycle of a CPU write
      begin
         int n = 0;
         cpu_we = 1'b1; cpu_addr = 16'h0040; cpu_wdata = 8'h77; cpu_req = 1'b1;
         do begin
            @(negedge clk);
            n++;
         end while (!mem_write && n < 20);
         chk("t5_write_started", {31'd0, mem_write}, 32'd1);
         @(posedge clk);
         #2 rst = 1'b1;
         cpu_req = 1'b0;
         #1;
         chk("t5_async_drop", {28'd0, mem_write, mem_read, owner}, 32'd0);
         repeat (2) @(negedge clk);
         rst = 1'b0;
         @(posedge clk);
         #1;
      end
      exp_grant.push_back(2'b01);
      cpu_xact(1'b0, 16'h1234, 8'h00, 8'hA5);

      // T6: cpu_rdata must hold across writes; loader reads back its T2 write
      exp_grant.push_back(2'b01);
      cpu_xact(1'b1, 16'h0050, 8'h11, 8'h00);
      exp_grant.push_back(2'b10);
      ldr_xact(1'b0, 16'h0100, 8'h00, 8'h3C);
      exp_grant.push_back(2'b01);
      cpu_xact(1'b0, 16'h0050, 8'h00, 8'h11);

      repeat (6) @(negedge clk);
      chk("queues_drained", exp_cpu.size() + exp_ldr.size() + exp_grant.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
